// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 bus target answering with DTACK, VPA or BERR over a 1-cycle sync RAM port
module m68k_bus_responder #(
    parameter int          WAIT_STATES  = 0,
    parameter int          BERR_TIMEOUT = 64,
    parameter logic [22:0] RAM_BASE     = 23'h000000,
    parameter logic [22:0] RAM_MASK     = 23'h7F0000,
    parameter logic [22:0] VPA_BASE     = 23'h7FF000,
    parameter logic [22:0] VPA_MASK     = 23'h7FF000
) (
    input  logic        PI_CLK,
    input  logic        RESET,
    input  logic        M68K_CLK,
    input  logic        M68K_E,
    input  logic [22:0] M68K_A,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic        M68K_VMA_n,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    output logic        M68K_VPA_n,
    output logic [22:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic [1:0]  MEM_BE,
    output logic        MEM_WE,
    output logic        MEM_RE,
    input  logic [15:0] MEM_RDATA
);
    localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, WAITDS = 3'd2, WAITCNT = 3'd3,
                           ACK = 3'd4, VPA = 3'd5, BERR = 3'd6, HOLD = 3'd7;
    logic [2:0]  state, c8m_s, e_s;
    logic [1:0]  as_q, uds_q, lds_q;
    logic [15:0] tcnt;
    logic [7:0]  wcnt;
    logic        re_d, fired, oe;
    logic        c8m_rise, c8m_fall, e_fall, as_s, ds_on, tmo, rel, ram_hit, vpa_hit, ack_rdy;

    assign c8m_rise = c8m_s[1] & ~c8m_s[2];
    assign c8m_fall = ~c8m_s[1] & c8m_s[2];
    assign e_fall   = ~e_s[1] & e_s[2];
    assign as_s     = as_q[1];
    assign ds_on    = ~(uds_q[1] & lds_q[1]);
    assign tmo      = tcnt == 16'(BERR_TIMEOUT);
    assign rel      = as_s && state != IDLE;
    assign ram_hit  = (M68K_A & RAM_MASK) == RAM_BASE;
    assign vpa_hit  = (M68K_A & VPA_MASK) == VPA_BASE;
    // read data lands in D_OUT on the same edge DTACK can fall, so only the issue cycle blocks it
    assign ack_rdy  = wcnt == 8'd0 && c8m_rise && !MEM_RE;

    assign M68K_DTACK_n = state != ACK;
    assign M68K_VPA_n   = !(state == VPA || state == HOLD);
    assign M68K_BERR_n  = state != BERR;
    assign M68K_D_OE    = oe && state != BERR;

    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            state      <= IDLE;
            c8m_s      <= '0;
            e_s        <= '0;
            as_q       <= 2'b11;
            uds_q      <= 2'b11;
            lds_q      <= 2'b11;
            tcnt       <= '0;
            wcnt       <= '0;
            re_d       <= 1'b0;
            fired      <= 1'b0;
            oe         <= 1'b0;
            M68K_D_OUT <= '0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            MEM_BE     <= '0;
            MEM_WE     <= 1'b0;
            MEM_RE     <= 1'b0;
        end else begin
            c8m_s  <= {c8m_s[1:0], M68K_CLK};
            e_s    <= {e_s[1:0], M68K_E};
            as_q   <= {as_q[0], M68K_AS_n};
            uds_q  <= {uds_q[0], M68K_UDS_n};
            lds_q  <= {lds_q[0], M68K_LDS_n};
            MEM_RE <= 1'b0;
            MEM_WE <= 1'b0;
            re_d   <= MEM_RE;
            if (re_d && state != IDLE) begin
                M68K_D_OUT <= MEM_RDATA;
                oe         <= 1'b1;
            end
            if (c8m_fall && !tmo)
                tcnt <= tcnt + 16'd1;
            case (state)
                IDLE: if (c8m_fall && !as_s) begin
                    state <= DECODE;
                    tcnt  <= '0;
                    fired <= 1'b0;
                end
                DECODE: begin
                    MEM_ADDR <= M68K_A;
                    state    <= ram_hit ? WAITDS : vpa_hit ? VPA : tmo ? BERR : DECODE;
                end
                WAITDS: if (ds_on) begin
                    MEM_BE    <= ~{uds_q[1], lds_q[1]};
                    MEM_RE    <= M68K_RW;
                    MEM_WE    <= !M68K_RW;
                    MEM_WDATA <= M68K_D_IN;
                    wcnt      <= 8'(WAIT_STATES);
                    state     <= WAITCNT;
                end else if (tmo) state <= BERR;
                WAITCNT: if (ack_rdy) state <= ACK;
                    else if (tmo) state <= BERR;
                    else if (c8m_fall && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
                VPA: if (!fired && !M68K_VMA_n && ds_on) begin
                    fired     <= 1'b1;
                    MEM_BE    <= ~{uds_q[1], lds_q[1]};
                    MEM_RE    <= M68K_RW;
                    MEM_WE    <= !M68K_RW;
                    MEM_WDATA <= M68K_D_IN;
                end else if (fired && e_fall && !MEM_RE && !re_d) state <= HOLD;
                    else if (tmo) state <= BERR;
                default: ;
            endcase
            // AS negation ends any cycle, completed or not, and cancels a strobe about to fire
            if (rel) begin
                state      <= IDLE;
                MEM_RE     <= 1'b0;
                MEM_WE     <= 1'b0;
                oe         <= 1'b0;
                M68K_D_OUT <= '0;
            end
        end
    end
endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: scoreboard bench for the 68000 bus target, 0- and 2-wait-state instances side by side
module tb_m68k_bus_responder;
    logic        pi_clk = 0, rst = 1, m68k_clk = 0, m68k_e = 0;
    logic [22:0] a = '0;
    logic        as_n = 1, uds_n = 1, lds_n = 1, rw = 1, vma_n = 1;
    logic [15:0] d_in = '0, ram_val = '0, rdata0 = '0, rdata2 = '0;
    logic [15:0] d_out0, d_out2, wdata0, wdata2;
    logic [22:0] maddr0, maddr2;
    logic [1:0]  be0, be2;
    logic        oe0, oe2, dtack0, dtack2, berr0, berr2, vpa0, vpa2, we0, we2, re0, re2;
    logic        dt0_q = 1;
    int          errors = 0, checks = 0;
    int          we0_n = 0, re0_n = 0, we2_n = 0, re2_n = 0;
    logic [17:0] wr_q[$];
    logic [15:0] rd_q[$];

    m68k_bus_responder #(.WAIT_STATES(0)) u0 (
        .PI_CLK(pi_clk), .RESET(rst), .M68K_CLK(m68k_clk), .M68K_E(m68k_e), .M68K_A(a),
        .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_VMA_n(vma_n),
        .M68K_D_IN(d_in), .M68K_D_OUT(d_out0), .M68K_D_OE(oe0), .M68K_DTACK_n(dtack0),
        .M68K_BERR_n(berr0), .M68K_VPA_n(vpa0), .MEM_ADDR(maddr0), .MEM_WDATA(wdata0),
        .MEM_BE(be0), .MEM_WE(we0), .MEM_RE(re0), .MEM_RDATA(rdata0));

    m68k_bus_responder #(.WAIT_STATES(2)) u2 (
        .PI_CLK(pi_clk), .RESET(rst), .M68K_CLK(m68k_clk), .M68K_E(m68k_e), .M68K_A(a),
        .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_VMA_n(vma_n),
        .M68K_D_IN(d_in), .M68K_D_OUT(d_out2), .M68K_D_OE(oe2), .M68K_DTACK_n(dtack2),
        .M68K_BERR_n(berr2), .M68K_VPA_n(vpa2), .MEM_ADDR(maddr2), .MEM_WDATA(wdata2),
        .MEM_BE(be2), .MEM_WE(we2), .MEM_RE(re2), .MEM_RDATA(rdata2));

    always #5 pi_clk = ~pi_clk;
    always #40 m68k_clk = ~m68k_clk;
    always #400 m68k_e = ~m68k_e;

    always @(posedge pi_clk) begin
        if (re0) rdata0 <= ram_val;
        if (re2) rdata2 <= ram_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge pi_clk) begin
        if (we0) begin
            we0_n++;
            check("we0_pending", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) check("wr0_be_data", 32'({be0, wdata0}), 32'(wr_q.pop_front()));
        end
        if (re0) re0_n++;
        if (we2) we2_n++;
        if (re2) re2_n++;
        if (dt0_q && !dtack0 && rw) begin
            check("rd0_pending", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) check("rd0_dout_at_dtack", 32'(d_out0), 32'(rd_q.pop_front()));
            check("rd0_oe_at_dtack", 32'(oe0), 1);
        end
        dt0_q = dtack0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    task automatic start(input logic [22:0] addr, input logic r, input logic [1:0] ds, input logic [15:0] d);
        @(posedge m68k_clk); #1;
        a = addr; rw = r; d_in = d;
        @(negedge m68k_clk); #1;
        as_n = 0;
        if (r) {uds_n, lds_n} = ds;
        else begin
            @(negedge m68k_clk); #1;
            {uds_n, lds_n} = ds;
        end
    endtask

    task automatic wait_ack(output int l0, output int l2);
        l0 = -1; l2 = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge pi_clk); #1;
            if (!dtack0 && l0 < 0) l0 = n;
            if (!dtack2 && l2 < 0) l2 = n;
            if (l0 > 0 && l2 > 0) break;
        end
    endtask

    task automatic end_cycle(input string tag);
        @(negedge m68k_clk); #1;
        as_n = 1; uds_n = 1; lds_n = 1;
        repeat (6) @(posedge pi_clk);
        #1;
        check({tag, "_dtack_rel"}, 32'(dtack0), 1);
        check({tag, "_berr_rel"}, 32'(berr0), 1);
        check({tag, "_vpa_rel"}, 32'(vpa0), 1);
        check({tag, "_oe_rel"}, 32'(oe0), 0);
        repeat (10) @(posedge pi_clk);
    endtask

    initial begin
        int l0, l2, nf, r0, w0, r2, w2;
        logic dt_low;
        repeat (3) @(posedge pi_clk);
        #1;
        check("rst_dtack", 32'(dtack0), 1);
        check("rst_berr", 32'(berr0), 1);
        check("rst_vpa", 32'(vpa0), 1);
        check("rst_oe", 32'(oe0), 0);
        check("rst_dout", 32'(d_out0), 0);
        check("rst_strobes", 32'({we0, re0, be0}), 0);
        rst = 0;
        repeat (10) @(posedge pi_clk);

        // 0-wait read at A=000010
        r0 = re0_n; w0 = we0_n;
        ram_val = 16'hBEEF;
        rd_q.push_back(16'hBEEF);
        start(23'h000010, 1, 2'b00, '0);
        wait_ack(l0, l2);
        check("rd_ack0_seen", 32'(l0 > 0), 1);
        check("rd_ack0_first_rise", 32'(l0 <= 10), 1);
        check("rd_ws2_delay", 32'(l2 - l0), 16);
        check("rd_addr0", 32'(maddr0), 32'h000010);
        repeat (20) @(posedge pi_clk);
        #1;
        check("rd_dout0_hold", 32'(d_out0), 32'hBEEF);
        check("rd_dout2", 32'(d_out2), 32'hBEEF);
        check("rd_re0_once", 32'(re0_n - r0), 1);
        check("rd_no_we0", 32'(we0_n - w0), 0);
        end_cycle("rd");

        // write with UDS only, compare 0- and 2-wait DTACK timing
        r0 = re0_n; w0 = we0_n; w2 = we2_n;
        wr_q.push_back({2'b10, 16'h1234});
        start(23'h000020, 0, 2'b01, 16'h1234);
        wait_ack(l0, l2);
        check("wr_ack0_seen", 32'(l0 > 0), 1);
        check("wr_ws2_delay", 32'(l2 - l0), 16);
        check("wr_be2", 32'(be2), 32'b10);
        check("wr_data2", 32'(wdata2), 32'h1234);
        check("wr_addr2", 32'(maddr2), 32'h000020);
        end_cycle("wr");
        check("wr_we0_once", 32'(we0_n - w0), 1);
        check("wr_we2_once", 32'(we2_n - w2), 1);
        check("wr_no_re0", 32'(re0_n - r0), 0);

        // unmapped address times out into BERR
        r0 = re0_n; w0 = we0_n;
        dt_low = 0;
        start(23'h400000, 1, 2'b00, '0);
        nf = 0;
        while (berr0 && nf < 100) begin
            @(negedge m68k_clk);
            nf++;
            #60;
            if (!dtack0) dt_low = 1;
        end
        check("berr_asserted", 32'(berr0), 0);
        check("berr_latency", 32'(nf >= 64 && nf <= 66), 1);
        check("berr_no_dtack", 32'(dt_low), 0);
        check("berr_no_strobes", 32'((re0_n - r0) + (we0_n - w0)), 0);
        check("berr_oe", 32'(oe0), 0);
        end_cycle("berr");

        // VPA region read paced by E
        r0 = re0_n;
        ram_val = 16'h00A5;
        dt_low = 0;
        start(23'h7FF010, 1, 2'b00, '0);
        for (int n = 0; n < 40 && vpa0; n++) begin
            @(posedge pi_clk); #1;
        end
        check("vpa_asserted", 32'(vpa0), 0);
        vma_n = 0;
        @(posedge m68k_e);
        @(negedge m68k_e);
        #1;
        check("vpa_dout_at_efall", 32'(d_out0), 32'h00A5);
        check("vpa_oe_at_efall", 32'(oe0), 1);
        repeat (10) begin
            @(posedge pi_clk); #1;
            if (!dtack0) dt_low = 1;
        end
        check("vpa_held", 32'(vpa0), 0);
        check("vpa_no_dtack", 32'(dt_low), 0);
        check("vpa_re_once", 32'(re0_n - r0), 1);
        end_cycle("vpa");
        vma_n = 1;

        // RESET while the 2-wait instance sits in WAITCNT
        r2 = re2_n;
        ram_val = 16'h2222;
        rd_q.push_back(16'h2222);
        start(23'h000050, 1, 2'b00, '0);
        for (int n = 0; n < 40 && re2_n == r2; n++) @(posedge pi_clk);
        repeat (4) @(posedge pi_clk);
        #1;
        check("rstmid_pre_dtack2", 32'(dtack2), 1);
        rst = 1;
        @(posedge pi_clk);
        #1;
        rst = 0; as_n = 1; uds_n = 1; lds_n = 1;
        check("rstmid_dtack2", 32'(dtack2), 1);
        check("rstmid_oe2", 32'(oe2), 0);
        check("rstmid_dtack0", 32'(dtack0), 1);
        check("rstmid_oe0", 32'(oe0), 0);
        repeat (20) @(posedge pi_clk);
        #1;
        check("rstmid_idle_dtack2", 32'(dtack2), 1);

        // aborted write: AS negated before DS
        w0 = we0_n; w2 = we2_n;
        @(posedge m68k_clk); #1;
        a = 23'h000030; rw = 0; d_in = 16'h5555;
        @(negedge m68k_clk); #1;
        as_n = 0;
        @(negedge m68k_clk); #1;
        as_n = 1;
        repeat (20) @(posedge pi_clk);
        #1;
        check("abort_no_we0", 32'(we0_n - w0), 0);
        check("abort_no_we2", 32'(we2_n - w2), 0);
        check("abort_dtack", 32'(dtack0), 1);
        check("abort_berr", 32'(berr0), 1);

        // next cycle completes normally
        r0 = re0_n;
        ram_val = 16'h1357;
        rd_q.push_back(16'h1357);
        start(23'h000040, 1, 2'b00, '0);
        wait_ack(l0, l2);
        check("post_ack0_seen", 32'(l0 > 0), 1);
        check("post_ws2_delay", 32'(l2 - l0), 16);
        check("post_dout2", 32'(d_out2), 32'h1357);
        check("post_re0_once", 32'(re0_n - r0), 1);
        end_cycle("post");

        check("rd_q_drained", 32'(rd_q.size()), 0);
        check("wr_q_drained", 32'(wr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
